av2_itx_scheduler: RTL and testbench
====================================

# av2_itx_scheduler

Round-robin scheduler that shares one `av2_inverse_transform_simple` engine between up to four transform-block requesters (e.g. Y/U/V plane decoders). It accepts one request at a time, latches its transform parameters, drives the engine's start/ready handshake, and returns a tagged completion. A watchdog aborts a job the engine never finishes. Sits between the residual/coefficient front-end and the inverse transform datapath.

## Interface
- `NUM_REQ`, 3: number of requesters, legal range 1..4.
- `TIMEOUT_CYCLES`, 4096: watchdog limit in cycles, 16-bit; 0 disables the watchdog.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester request.
- `req_ready` out NUM_REQ: one-hot accept.
- `req_tx_width` in 6*NUM_REQ: packed, requester k at bits [6k+5:6k].
- `req_tx_height` in 6*NUM_REQ: packed, same layout.
- `req_tx_type` in 4*NUM_REQ: packed.
- `req_num_coeffs` in 16*NUM_REQ: packed.
- `itx_start` out 1: engine start pulse.
- `itx_tx_width` out 6, `itx_tx_height` out 6, `itx_tx_type` out 4, `itx_num_coeffs` out 16: latched job parameters.
- `itx_sel` out 2: index of the granted requester; steers the coefficient/pixel muxes.
- `itx_valid` in 1: engine output valid.
- `itx_ready` out 1: ready to engine.
- `itx_done` in 1: engine done pulse.
- `cpl_valid` out 1, `cpl_id` out 2, `cpl_timeout` out 1, `cpl_ready` in 1: completion channel.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, LAUNCH, WAIT_VALID, WAIT_DONE, COMPLETE.
- **IDLE:**
  - Grant goes to the first asserted `req_valid` searching from `ptr` upward, with modulo NUM_REQ wrap.
  - `req_ready` is combinational: one-hot on the winner, and only in IDLE.
  - On accept, latch the winner's params into the `itx_*` registers, set `itx_sel`, and set `ptr` = (winner+1) mod NUM_REQ.
  - Then go to LAUNCH.
- **LAUNCH:**
  - `itx_start`=1 for this cycle only.
  - Clear the watchdog counter, then go to WAIT_VALID.
- **WAIT_VALID:**
  - `itx_ready`=1, combinational from state.
  - On `itx_valid`=1, go to WAIT_DONE.
- **WAIT_DONE:** on `itx_done`=1, go to COMPLETE with `cpl_timeout`=0.
- **Watchdog:**
  - The counter increments every cycle in WAIT_VALID and WAIT_DONE.
  - When it equals TIMEOUT_CYCLES-1 without a transition, go to COMPLETE with `cpl_timeout`=1.
  - Progress in the same cycle wins over timeout.
- **COMPLETE:**
  - `cpl_valid`=1, `cpl_id`=`itx_sel`.
  - Hold until `cpl_ready`, then go to IDLE.
- **Ignored inputs:**
  - `itx_valid` outside WAIT_VALID.
  - `itx_done` outside WAIT_DONE.
  - `req_valid` outside IDLE.
- Latched params and `itx_sel` stay stable from LAUNCH until the return to IDLE.
- The scheduler does not drop requests; requesters hold `req_valid` until accepted.
- **Reset:**
  - State IDLE, `ptr`=0, watchdog=0.
  - All outputs 0: `itx_*` params 0, `itx_sel`=0, `cpl_id`=0, `cpl_timeout`=0.
  - Reset mid-job abandons the job with no completion; the engine is reset by the same `rst_n`.

## Timing
- Accept in cycle T.
- `itx_start` high in T+1.
- WAIT_VALID from T+2.
- `itx_valid` sampled in cycle V: WAIT_DONE from V+1, `itx_ready` low from V+1.
- `itx_done` in cycle D: `cpl_valid` high from D+1.
- Completion handshake in cycle C: IDLE in C+1, and the next accept can happen in C+1.
- Minimum turnaround, accept to next accept: 5 cycles plus engine latency.
- Timeout: `cpl_valid` rises TIMEOUT_CYCLES cycles after entering WAIT_VALID, counting only WAIT_VALID and WAIT_DONE cycles.
- `busy`, `itx_start`, `cpl_*` and `itx_*` params are registered. `req_ready` and `itx_ready` are decoded from the state register.

## Test plan
- **Single request:** req 0 with 8x8, type 2, 64 coeffs.
  - `req_ready[0]` in T, `itx_start` in T+1 with width 8, height 8, type 2.
  - `cpl_valid` with `cpl_id`=0, `cpl_timeout`=0 one cycle after `itx_done`.
- **Round robin:** `req_valid`=3'b111 held continuously.
  - Grants in order 0,1,2,0.
  - `itx_sel` matches each grant; no grant while `busy`.
- **Wrap and skip:** after a grant to 2, assert only req 1.
  - Next grant is 1, not stalled by `ptr` pointing at 0.
- **Completion backpressure:** `cpl_ready` held low 10 cycles after done.
  - `cpl_valid` and `cpl_id` stable for those 10 cycles.
  - No new `req_ready`; IDLE one cycle after `cpl_ready`.
- **Watchdog:** TIMEOUT_CYCLES=16, engine never raises `itx_valid`.
  - `cpl_valid` with `cpl_timeout`=1 after 16 WAIT_VALID cycles.
  - A later `itx_valid` in IDLE is ignored.
- **Reset mid-job:** assert `rst_n`=0 in WAIT_DONE.
  - All outputs 0 asynchronously and no `cpl_valid`.
  - After release, req 0 wins over req 2 (`ptr`=0).

Source files
------------

// File: rtl/av2_itx_scheduler.sv
// Round-robin arbiter that shares one inverse-transform engine among up to four
// requesters, with a watchdog that aborts jobs the engine never finishes.
module av2_itx_scheduler #(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [6*NUM_REQ-1:0]    req_tx_width,
    input  logic [6*NUM_REQ-1:0]    req_tx_height,
    input  logic [4*NUM_REQ-1:0]    req_tx_type,
    input  logic [16*NUM_REQ-1:0]   req_num_coeffs,
    output logic                    itx_start,
    output logic [5:0]              itx_tx_width,
    output logic [5:0]              itx_tx_height,
    output logic [3:0]              itx_tx_type,
    output logic [15:0]             itx_num_coeffs,
    output logic [1:0]              itx_sel,
    input  logic                    itx_valid,
    output logic                    itx_ready,
    input  logic                    itx_done,
    output logic                    cpl_valid,
    output logic [1:0]              cpl_id,
    output logic                    cpl_timeout,
    input  logic                    cpl_ready,
    output logic                    busy
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LAUNCH     = 3'd1;
    localparam logic [2:0] S_WAIT_VALID = 3'd2;
    localparam logic [2:0] S_WAIT_DONE  = 3'd3;
    localparam logic [2:0] S_COMPLETE   = 3'd4;

    localparam logic [15:0] WD_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  NR       = 3'(NUM_REQ);
    localparam logic [2:0]  LAST_REQ = 3'(NUM_REQ - 1);

    logic [2:0]          state;
    logic [1:0]          ptr;
    logic [15:0]         wd_cnt;
    logic                wd_expired;

    logic                found;
    logic [1:0]          win;
    logic [NUM_REQ-1:0]  grant;
    logic [5:0]          sel_width;
    logic [5:0]          sel_height;
    logic [3:0]          sel_type;
    logic [15:0]         sel_coeffs;

    // Search from ptr upward with wrap; first asserted request wins.
    always_comb begin
        logic [2:0] cand;
        cand       = '0;
        found      = 1'b0;
        win        = '0;
        grant      = '0;
        sel_width  = '0;
        sel_height = '0;
        sel_type   = '0;
        sel_coeffs = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + 3'(i);
            if (cand >= NR) begin
                cand = cand - NR;
            end
            if (!found && req_valid[cand[1:0]]) begin
                found             = 1'b1;
                win               = cand[1:0];
                grant[cand[1:0]]  = 1'b1;
                sel_width         = req_tx_width[6*cand[1:0] +: 6];
                sel_height        = req_tx_height[6*cand[1:0] +: 6];
                sel_type          = req_tx_type[4*cand[1:0] +: 4];
                sel_coeffs        = req_num_coeffs[16*cand[1:0] +: 16];
            end
        end
    end

    assign req_ready  = (state == S_IDLE) ? grant : '0;
    assign itx_ready  = (state == S_WAIT_VALID);
    assign wd_expired = (TIMEOUT_CYCLES != 0) && (wd_cnt == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            ptr            <= '0;
            wd_cnt         <= '0;
            itx_start      <= 1'b0;
            itx_tx_width   <= '0;
            itx_tx_height  <= '0;
            itx_tx_type    <= '0;
            itx_num_coeffs <= '0;
            itx_sel        <= '0;
            cpl_valid      <= 1'b0;
            cpl_id         <= '0;
            cpl_timeout    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            itx_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        itx_tx_width   <= sel_width;
                        itx_tx_height  <= sel_height;
                        itx_tx_type    <= sel_type;
                        itx_num_coeffs <= sel_coeffs;
                        itx_sel        <= win;
                        ptr            <= ({1'b0, win} == LAST_REQ) ? 2'd0 : win + 2'd1;
                        itx_start      <= 1'b1;
                        busy           <= 1'b1;
                        state          <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wd_cnt <= '0;
                    state  <= S_WAIT_VALID;
                end
                S_WAIT_VALID: begin
                    wd_cnt <= wd_cnt + 16'd1;
                    // Engine progress in the same cycle takes priority over the watchdog.
                    if (itx_valid) begin
                        state <= S_WAIT_DONE;
                    end else if (wd_expired) begin
                        cpl_valid   <= 1'b1;
                        cpl_id      <= itx_sel;
                        cpl_timeout <= 1'b1;
                        state       <= S_COMPLETE;
                    end
                end
                S_WAIT_DONE: begin
                    wd_cnt <= wd_cnt + 16'd1;
                    if (itx_done || wd_expired) begin
                        cpl_valid   <= 1'b1;
                        cpl_id      <= itx_sel;
                        cpl_timeout <= !itx_done;
                        state       <= S_COMPLETE;
                    end
                end
                S_COMPLETE: begin
                    if (cpl_ready) begin
                        cpl_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_av2_itx_scheduler.sv
// Directed bench for av2_itx_scheduler: grants, round robin, backpressure,
// watchdog timeout and asynchronous reset in the middle of a job.
module tb_av2_itx_scheduler;

    logic        clk;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [17:0] req_tx_width;
    logic [17:0] req_tx_height;
    logic [11:0] req_tx_type;
    logic [47:0] req_num_coeffs;
    logic        itx_start;
    logic [5:0]  itx_tx_width;
    logic [5:0]  itx_tx_height;
    logic [3:0]  itx_tx_type;
    logic [15:0] itx_num_coeffs;
    logic [1:0]  itx_sel;
    logic        itx_valid;
    logic        itx_ready;
    logic        itx_done;
    logic        cpl_valid;
    logic [1:0]  cpl_id;
    logic        cpl_timeout;
    logic        cpl_ready;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Per-requester parameters: req0 8x8 type 2, req1 16x4 type 5, req2 4x32 type 9.
    logic [5:0]  w_tab [3] = '{6'd8, 6'd16, 6'd4};
    logic [5:0]  h_tab [3] = '{6'd8, 6'd4, 6'd32};
    logic [3:0]  t_tab [3] = '{4'd2, 4'd5, 4'd9};
    logic [15:0] n_tab [3] = '{16'd64, 16'd64, 16'd128};

    av2_itx_scheduler #(
        .NUM_REQ        (3),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_tx_width   (req_tx_width),
        .req_tx_height  (req_tx_height),
        .req_tx_type    (req_tx_type),
        .req_num_coeffs (req_num_coeffs),
        .itx_start      (itx_start),
        .itx_tx_width   (itx_tx_width),
        .itx_tx_height  (itx_tx_height),
        .itx_tx_type    (itx_tx_type),
        .itx_num_coeffs (itx_num_coeffs),
        .itx_sel        (itx_sel),
        .itx_valid      (itx_valid),
        .itx_ready      (itx_ready),
        .itx_done       (itx_done),
        .cpl_valid      (cpl_valid),
        .cpl_id         (cpl_id),
        .cpl_timeout    (cpl_timeout),
        .cpl_ready      (cpl_ready),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        req_valid = '0;
        itx_valid = 1'b0;
        itx_done  = 1'b0;
        cpl_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Full job with a prompt engine; hold = cycles cpl_ready stays low after completion.
    task automatic do_job(input logic [1:0] id, input int hold);
        logic [2:0] onehot;
        onehot = 3'b001 << id;
        #1;
        check("req_ready", req_ready, onehot);
        @(posedge clk); #1;
        check("itx_start", itx_start, 1);
        check("itx_sel", itx_sel, id);
        check("itx_width", itx_tx_width, w_tab[id]);
        check("itx_height", itx_tx_height, h_tab[id]);
        check("itx_type", itx_tx_type, t_tab[id]);
        check("itx_coeffs", itx_num_coeffs, n_tab[id]);
        check("busy_launch", busy, 1);
        check("no_grant_launch", req_ready, 0);
        @(posedge clk); #1;
        check("start_pulse", itx_start, 0);
        check("itx_ready_wv", itx_ready, 1);
        check("no_grant_wv", req_ready, 0);
        itx_valid = 1'b1;
        @(posedge clk); #1;
        itx_valid = 1'b0;
        check("itx_ready_wd", itx_ready, 0);
        check("cpl_early", cpl_valid, 0);
        itx_done = 1'b1;
        @(posedge clk); #1;
        itx_done = 1'b0;
        check("cpl_valid", cpl_valid, 1);
        check("cpl_id", cpl_id, id);
        check("cpl_timeout", cpl_timeout, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("cpl_hold_valid", cpl_valid, 1);
            check("cpl_hold_id", cpl_id, id);
            check("cpl_hold_noready", req_ready, 0);
        end
        cpl_ready = 1'b1;
        @(posedge clk); #1;
        cpl_ready = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_cpl", cpl_valid, 0);
    endtask

    // Engine stalls in WAIT_VALID; rescue drives itx_valid in the last watchdog cycle.
    task automatic timeout_job(input logic [1:0] id, input logic rescue);
        logic [2:0] onehot;
        onehot = 3'b001 << id;
        #1;
        check("wd_req_ready", req_ready, onehot);
        @(posedge clk); #1;
        req_valid = '0;
        check("wd_start", itx_start, 1);
        @(posedge clk); #1;
        check("wd_enter_wv", itx_ready, 1);
        for (int i = 1; i < 16; i++) begin
            @(posedge clk); #1;
            check("wd_waiting", {itx_ready, cpl_valid}, 2'b10);
        end
        if (rescue) begin
            itx_valid = 1'b1;
            @(posedge clk); #1;
            itx_valid = 1'b0;
            check("wd_rescue_cpl", cpl_valid, 0);
            check("wd_rescue_ready", itx_ready, 0);
            itx_done = 1'b1;
            @(posedge clk); #1;
            itx_done = 1'b0;
            check("wd_rescue_done", cpl_valid, 1);
            check("wd_rescue_to", cpl_timeout, 0);
            check("wd_rescue_id", cpl_id, id);
        end else begin
            @(posedge clk); #1;
            check("wd_cpl_valid", cpl_valid, 1);
            check("wd_cpl_to", cpl_timeout, 1);
            check("wd_cpl_id", cpl_id, id);
            check("wd_itx_ready", itx_ready, 0);
        end
        cpl_ready = 1'b1;
        @(posedge clk); #1;
        cpl_ready = 1'b0;
        check("wd_idle", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL bench_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req_tx_width   = {6'd4, 6'd16, 6'd8};
        req_tx_height  = {6'd32, 6'd4, 6'd8};
        req_tx_type    = {4'd9, 4'd5, 4'd2};
        req_num_coeffs = {16'd128, 16'd64, 16'd64};

        reset_dut();
        check("rst_busy", busy, 0);
        check("rst_start", itx_start, 0);
        check("rst_sel", itx_sel, 0);
        check("rst_params", {itx_tx_width, itx_tx_height, itx_tx_type, itx_num_coeffs}, 0);
        check("rst_cpl", {cpl_valid, cpl_id, cpl_timeout}, 0);
        check("rst_ready", {req_ready, itx_ready}, 0);

        // Single request from requester 0.
        req_valid = 3'b001;
        do_job(2'd0, 0);
        req_valid = '0;

        // Round robin with all requests held, then wrap-and-skip to req 1.
        reset_dut();
        req_valid = 3'b111;
        do_job(2'd0, 0);
        do_job(2'd1, 0);
        do_job(2'd2, 0);
        do_job(2'd0, 0);
        do_job(2'd1, 0);
        do_job(2'd2, 0);
        req_valid = 3'b010;
        do_job(2'd1, 0);

        // Completion backpressure for 10 cycles.
        req_valid = 3'b100;
        do_job(2'd2, 10);
        req_valid = '0;

        // Watchdog expiry, then stray engine strobes while idle.
        req_valid = 3'b001;
        timeout_job(2'd0, 1'b0);
        itx_valid = 1'b1;
        itx_done  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        itx_valid = 1'b0;
        itx_done  = 1'b0;
        check("stray_busy", busy, 0);
        check("stray_cpl", cpl_valid, 0);
        check("stray_start", itx_start, 0);

        // Progress in the final watchdog cycle beats the timeout.
        req_valid = 3'b010;
        timeout_job(2'd1, 1'b1);

        // Reset while waiting for done: ptr was 2, so without reset req 2 would win.
        req_valid = 3'b010;
        #1;
        check("mid_req_ready", req_ready, 3'b010);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        itx_valid = 1'b1;
        @(posedge clk); #1;
        itx_valid = 1'b0;
        check("mid_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_sel", itx_sel, 0);
        check("arst_params", {itx_tx_width, itx_tx_height, itx_tx_type, itx_num_coeffs}, 0);
        check("arst_ready", itx_ready, 0);
        check("arst_cpl", {cpl_valid, cpl_id, cpl_timeout}, 0);
        itx_done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        itx_done = 1'b0;
        rst_n    = 1'b1;
        check("arst_no_cpl", cpl_valid, 0);
        req_valid = 3'b101;
        do_job(2'd0, 0);
        req_valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
